// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode width, opcode
// enumeration and small opcode-class helpers used by the datapath.
package multicycle_alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_LHI   = 5'd2,
        ALU_NAND  = 5'd3,
        ALU_NOR   = 5'd4,
        ALU_XNOR  = 5'd5,
        ALU_NOT   = 5'd6,
        ALU_AND   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_XOR   = 5'd9,
        ALU_LRS   = 5'd10,
        ALU_ARS   = 5'd11,
        ALU_RR    = 5'd12,
        ALU_LLS   = 5'd13,
        ALU_ALS   = 5'd14,
        ALU_RL    = 5'd15,
        ALU_MUL   = 5'd16,
        ALU_MULHU = 5'd17
    } alu_op_e;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op >= ALU_LRS) && (op <= ALU_RL);
    endfunction

    function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/multicycle_alu_iterative_multiplier.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// Ports: clk, reset (sync, active-high), start, a, b -> busy, done, product.
module iterative_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] src_hi, src_lo, src_m, addend;
    logic [WIDTH:0]   sum;

    // The first partial product is folded into the start cycle so the
    // whole multiply spans exactly WIDTH step cycles.
    always_comb begin
        src_hi  = start ? '0 : hi_q;
        src_lo  = start ? b  : lo_q;
        src_m   = start ? a  : mcand_q;
        addend  = src_lo[0] ? src_m : '0;
        sum     = {1'b0, src_hi} + {1'b0, addend};

        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (start) begin
            hi_d    = sum[WIDTH:1];
            lo_d    = {sum[0], src_lo[WIDTH-1:1]};
            mcand_d = a;
            cnt_d   = CNT_W'(WIDTH - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            hi_d  = sum[WIDTH:1];
            lo_d  = {sum[0], src_lo[WIDTH-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = {hi_q, lo_q};

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked multi-cycle ALU: logic/arith in one cycle, iterative shifts
// and multiply. Ports: clk, reset, in_valid/in_ready, op, a, b, cin, shamt,
// out_valid/out_ready, result, cout, zero, negative, overflow.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    input  logic [SHAMT_W-1:0]  shamt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                cout,
    output logic                zero,
    output logic                negative,
    output logic                overflow
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [ALU_OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0]     acc_q, acc_d, result_q, result_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 cout_q, cout_d, zero_q, zero_d;
    logic                 neg_q, neg_d, ovf_q, ovf_d;

    logic                 load_res, cout_n, ovf_n;
    logic [WIDTH-1:0]     res_n, shifted;
    logic [WIDTH:0]       arith;
    logic                 shift_out;
    logic                 mul_start, mul_done, mul_busy_unused;
    logic [2*WIDTH-1:0]   product;

    iterative_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy_unused),
        .done    (mul_done),
        .product (product)
    );

    // One-bit step of the shift/rotate accumulator.
    always_comb begin
        shifted   = acc_q;
        shift_out = 1'b0;
        case (op_q)
            ALU_LRS: begin
                shifted   = {1'b0, acc_q[WIDTH-1:1]};
                shift_out = acc_q[0];
            end
            ALU_ARS: begin
                shifted   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                shift_out = acc_q[0];
            end
            ALU_RR: begin
                shifted   = {acc_q[0], acc_q[WIDTH-1:1]};
                shift_out = acc_q[0];
            end
            ALU_LLS, ALU_ALS: begin
                shifted   = {acc_q[WIDTH-2:0], 1'b0};
                shift_out = acc_q[WIDTH-1];
            end
            ALU_RL: begin
                shifted   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                shift_out = acc_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        load_res  = 1'b0;
        res_n     = '0;
        cout_n    = 1'b0;
        ovf_n     = 1'b0;
        arith     = '0;
        mul_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (is_shift_op(op)) begin
                        if (shamt == '0) begin
                            res_n    = a;
                            load_res = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            acc_d   = a;
                            cnt_d   = shamt;
                            state_d = S_SHIFT;
                        end
                    end else if (is_mul_op(op)) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        case (op)
                            ALU_ADD: begin
                                arith  = {1'b0, a} + {1'b0, b}
                                       + {{WIDTH{1'b0}}, cin};
                                res_n  = arith[WIDTH-1:0];
                                cout_n = arith[WIDTH];
                                ovf_n  = (a[WIDTH-1] == b[WIDTH-1])
                                      && (arith[WIDTH-1] != a[WIDTH-1]);
                            end
                            ALU_SUB: begin
                                // Top bit of the WIDTH+1 difference is the borrow.
                                arith  = {1'b0, a} - ({1'b0, b}
                                       + {{WIDTH{1'b0}}, cin});
                                res_n  = arith[WIDTH-1:0];
                                cout_n = arith[WIDTH];
                                ovf_n  = (a[WIDTH-1] != b[WIDTH-1])
                                      && (arith[WIDTH-1] != a[WIDTH-1]);
                            end
                            ALU_LHI:  res_n = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]};
                            ALU_NAND: res_n = ~(a & b);
                            ALU_NOR:  res_n = ~(a | b);
                            ALU_XNOR: res_n = ~(a ^ b);
                            ALU_NOT:  res_n = ~a;
                            ALU_AND:  res_n = a & b;
                            ALU_OR:   res_n = a | b;
                            ALU_XOR:  res_n = a ^ b;
                            default:  res_n = '0;
                        endcase
                        load_res = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d  = shifted;
                cnt_d  = cnt_q - SHAMT_W'(1);
                cout_d = shift_out;
                if (cnt_q == SHAMT_W'(1)) begin
                    res_n    = shifted;
                    cout_n   = shift_out;
                    load_res = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    res_n    = (op_q == ALU_MULHU) ? product[2*WIDTH-1:WIDTH]
                                                   : product[WIDTH-1:0];
                    load_res = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_res) begin
            result_d = res_n;
            cout_d   = cout_n;
            zero_d   = (res_n == '0);
            neg_d    = res_n[WIDTH-1];
            ovf_d    = ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=16): directed vector table,
// handshake/reset corner sequences and randomized ops against a model.
module tb_multicycle_alu;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [3:0]  sh;
        logic [15:0] r;
        logic        co;
        logic        z;
        logic        n;
        logic        o;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, cin;
    logic [4:0]  op;
    logic [15:0] a, b;
    logic [3:0]  shamt;
    logic        in_ready, out_valid, cout, zero, negative, overflow;
    logic [15:0] result;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model written directly from the arithmetic definitions.
    function automatic vec_t model(input vec_t v);
        vec_t        m;
        logic [16:0] s;
        logic [31:0] p;
        logic signed [15:0] sa;
        int          n;
        m = v;
        m.r = '0; m.co = 1'b0; m.o = 1'b0; m.lat = 1;
        n = int'(v.sh);
        sa = v.a;
        p = 32'(v.a) * 32'(v.b);
        case (v.op)
            5'd0: begin
                s = 17'(v.a) + 17'(v.b) + 17'(v.cin);
                m.r = s[15:0]; m.co = s[16];
                m.o = (v.a[15] == v.b[15]) && (m.r[15] != v.a[15]);
            end
            5'd1: begin
                s = 17'(v.a) - 17'(v.b) - 17'(v.cin);
                m.r = s[15:0]; m.co = s[16];
                m.o = (v.a[15] != v.b[15]) && (m.r[15] != v.a[15]);
            end
            5'd2: m.r = {v.b[7:0], v.a[7:0]};
            5'd3: m.r = ~(v.a & v.b);
            5'd4: m.r = ~(v.a | v.b);
            5'd5: m.r = ~(v.a ^ v.b);
            5'd6: m.r = ~v.a;
            5'd7: m.r = v.a & v.b;
            5'd8: m.r = v.a | v.b;
            5'd9: m.r = v.a ^ v.b;
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
                if (n == 0) begin
                    m.r = v.a;
                end else begin
                    m.lat = 1 + n;
                    case (v.op)
                        5'd10: begin m.r = v.a >> n; m.co = v.a[n-1]; end
                        5'd11: begin m.r = sa >>> n; m.co = v.a[n-1]; end
                        5'd12: begin
                            m.r = (v.a >> n) | (v.a << (16 - n));
                            m.co = v.a[n-1];
                        end
                        5'd15: begin
                            m.r = (v.a << n) | (v.a >> (16 - n));
                            m.co = v.a[16-n];
                        end
                        default: begin m.r = v.a << n; m.co = v.a[16-n]; end
                    endcase
                end
            end
            5'd16: begin m.r = p[15:0];  m.lat = 17; end
            5'd17: begin m.r = p[31:16]; m.lat = 17; end
            default: m.r = '0;
        endcase
        m.z = (m.r == 16'h0);
        m.n = m.r[15];
        return m;
    endfunction

    task automatic run_op(input vec_t v, output vec_t g, output logic rdy_busy);
        int guard = 0;
        g = v;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", in_ready, 1);
        op = v.op; a = v.a; b = v.b; cin = v.cin; shamt = v.sh;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        g.lat = 1;
        rdy_busy = 1'b0;
        while (!out_valid && g.lat < 100) begin
            if (in_ready) rdy_busy = 1'b1;
            step();
            g.lat++;
        end
        if (in_ready) rdy_busy = 1'b1;
        g.r = result; g.co = cout; g.z = zero; g.n = negative; g.o = overflow;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input vec_t e);
        vec_t g;
        logic rb;
        run_op(e, g, rb);
        chk({tag, "_result"}, g.r, e.r);
        chk({tag, "_cout"}, g.co, e.co);
        chk({tag, "_zero"}, g.z, e.z);
        chk({tag, "_neg"}, g.n, e.n);
        chk({tag, "_ovf"}, g.o, e.o);
        chk({tag, "_latency"}, g.lat, e.lat);
        chk({tag, "_busy_ready"}, rb, 1'b0);
    endtask

    vec_t tbl[18];

    initial begin
        vec_t v, g;
        logic rb;
        int   seen;

        //          op     a        b        cin   sh     r        co    z     n     o     lat
        tbl[0]  = '{5'd0,  16'hFFFF, 16'h0001, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[1]  = '{5'd1,  16'h8000, 16'h0001, 1'b0, 4'd0,  16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[2]  = '{5'd1,  16'h0003, 16'h0001, 1'b1, 4'd0,  16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{5'd11, 16'h8010, 16'h0000, 1'b0, 4'd4,  16'hF801, 1'b0, 1'b0, 1'b1, 1'b0, 5};
        tbl[4]  = '{5'd15, 16'h8001, 16'h0000, 1'b0, 4'd1,  16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[5]  = '{5'd13, 16'hA5A5, 16'h0000, 1'b0, 4'd0,  16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[6]  = '{5'd16, 16'h0123, 16'h0100, 1'b0, 4'd0,  16'h2300, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        tbl[7]  = '{5'd17, 16'hFFFF, 16'hFFFF, 1'b0, 4'd0,  16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 17};
        tbl[8]  = '{5'd20, 16'h1234, 16'h5678, 1'b1, 4'd3,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{5'd2,  16'h1234, 16'hABCD, 1'b0, 4'd0,  16'hCD34, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[10] = '{5'd1,  16'h0000, 16'h0001, 1'b0, 4'd0,  16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[11] = '{5'd10, 16'h8001, 16'h0000, 1'b0, 4'd15, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16};
        tbl[12] = '{5'd6,  16'hFFFF, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[13] = '{5'd3,  16'hF0F0, 16'hFF00, 1'b0, 4'd0,  16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[14] = '{5'd0,  16'h7FFF, 16'h0000, 1'b1, 4'd0,  16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[15] = '{5'd12, 16'h0001, 16'h0000, 1'b0, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        tbl[16] = '{5'd5,  16'h00FF, 16'h0F0F, 1'b0, 4'd0,  16'hF00F, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[17] = '{5'd14, 16'h4000, 16'h0000, 1'b0, 4'd2,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 3};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; cin = 1'b0; shamt = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 16'h0);
        chk("rst_flags", {cout, zero, negative, overflow}, 4'b0000);

        for (int i = 0; i < 18; i++) check_op($sformatf("vec%0d", i), tbl[i]);

        // Backpressure: result held, input ignored while DONE.
        v = '{5'd0, 16'h1111, 16'h2222, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        op = v.op; a = v.a; b = v.b; cin = v.cin; shamt = v.sh;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_result", result, 16'h3333);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_flags", {cout, zero, negative, overflow}, 4'b0000);
            if (i == 1) begin
                op = 5'd16; a = 16'hFFFF; b = 16'hFFFF;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        chk("bp_hold_result", result, 16'h3333);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_release_valid", out_valid, 1'b0);
        step();
        chk("bp_pulse_ignored", {in_ready, out_valid}, 2'b10);

        // Reset in the middle of a multiply discards it.
        v = '{5'd0, 16'h9000, 16'h9000, 1'b0, 4'd0, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        check_op("pre_rst", v);
        op = 5'd16; a = 16'h1234; b = 16'h5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, 16'h0);
        chk("midrst_flags", {cout, zero, negative, overflow}, 4'b0000);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("midrst_discarded", seen, 0);
        v = '{5'd0, 16'h0002, 16'h0003, 1'b0, 4'd0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        check_op("post_rst_add", v);
        v = '{5'd20, 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        check_op("post_rst_illegal", v);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            v.op  = 5'($urandom_range(0, 31));
            v.a   = 16'($urandom);
            v.b   = 16'($urandom);
            v.cin = 1'($urandom);
            v.sh  = 4'($urandom);
            v = model(v);
            run_op(v, g, rb);
            chk($sformatf("rnd%0d_op%0d_result", i, v.op), g.r, v.r);
            chk($sformatf("rnd%0d_op%0d_flags", i, v.op),
                {g.co, g.z, g.n, g.o}, {v.co, v.z, v.n, v.o});
            chk($sformatf("rnd%0d_op%0d_latency", i, v.op), g.lat, v.lat);
            chk($sformatf("rnd%0d_busy_ready", i), rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
